mux_arb_reg: RTL and testbench
==============================

# mux_arb_reg

Parametrised, registered N-channel multiplexer with valid/ready handshaking and round-robin or fixed-priority arbitration. It generalises the static 4:1, 19-bit select mux used in the datapath. It also serves as the merge point where several producers (iteration stages, operand sources) share one downstream consumer. The block holds one output register stage, so back-pressure is honoured without dropping or duplicating data.

## Interface
Parameters:
- WIDTH, 19, data width per channel (>=1)
- NCH, 4, number of input channels (>=2, need not be a power of two)
- FIXED_PRI, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- SW = $clog2(NCH), derived select width (not overridden)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  NCH  per-channel request
- in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready  out  NCH  per-channel accept; one-hot or zero
- force_en  in  1  static-select mode: only channel force_sel may be granted
- force_sel  in  SW  channel forced when force_en=1
- out_valid  out  1  output register holds a valid word
- out_data  out  WIDTH  registered selected data
- out_sel  out  SW  index of channel that produced out_data
- out_ready  in  1  consumer accepts out_data this cycle

## Operation
- load = !out_valid || out_ready (output slot free or draining this cycle).
- Eligible set: E[k] = in_valid[k]; if force_en, E = in_valid[force_sel] only. If force_sel >= NCH, E is empty.
- Grant g:
  - round-robin: first k with E[k], scanning from ptr upward with wrap-around NCH-1 -> 0
  - FIXED_PRI=1: lowest k with E[k]
- in_ready[g] = load && any(E); all other in_ready bits are 0. in_ready is combinational from in_valid, force_*, out_valid, out_ready and ptr. in_valid has no combinational dependence on in_ready.
- A transfer occurs on channel k when in_valid[k] && in_ready[k].
- On load with a grant:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1
  - ptr <= (g==NCH-1) ? 0 : g+1, round-robin mode only, and only when force_en=0
- On load with no grant: out_valid <= 0; out_data and out_sel hold their previous values.
- When !load (out_valid && !out_ready): out_valid, out_data, out_sel and ptr hold; all in_ready are 0.
- Producers must hold in_valid and in_data stable until accepted. The block tolerates a producer dropping in_valid; that channel is simply not granted.
- Reset: out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is 0 during reset. A word held in the output register is discarded; no transfer is counted in the reset cycle.

## Timing
- Latency: input transfer at edge n -> out_valid/out_data visible after edge n, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Simultaneous drain and fill (out_valid && out_ready && grant): the old word leaves and the new word is loaded in the same edge, with no bubble.
- Fairness: round-robin with all NCH channels continuously valid grants 0,1,...,NCH-1,0,... Any requesting channel waits at most NCH-1 grants.
- Reset takes priority over all loads in the same cycle.

## Test plan
- Reset/idle: assert reset 2 cycles with all in_valid=1. Require in_ready=0 and out_valid=0, out_data=0, out_sel=0 during reset; first grant after reset is channel 0.
- Round-robin rotation: NCH=4, all in_valid=1, in_data[k]=0x100+k, out_ready=1. Require out_sel sequence 0,1,2,3,0 on consecutive cycles and out_data 0x100..0x103,0x100.
- Back-pressure: hold out_ready=0 for 3 cycles after out_valid rises with data 0x7FFFF. Require out_data to stay 0x7FFFF, all in_ready=0 and ptr frozen. On release the next channel in order is granted with no bubble.
- Sparse/wrap: only channels 1 and 3 valid, ptr=2. Require grants 3 then 1 (wrap); channels 0 and 2 never see in_ready.
- Force mode: force_en=1, force_sel=2, all valid. Require only in_ready[2] and repeated out_sel=2, with ptr unchanged after force_en drops. force_sel=3 with in_valid[3]=0 -> out_valid falls to 0 after the drain.
- Fixed priority and NCH=3: FIXED_PRI=1, channels 1 and 2 valid. Require channel 1 granted every cycle while valid. Separately, round-robin with NCH=3 must wrap from ptr 2 to 0.

Source files
------------

// File: rtl/mux_arb_reg_if.sv
// mux_arb_reg_if
//   Bundles the producer-side and consumer-side handshake of mux_arb_reg.
//   Parameters WIDTH/NCH must match the mux_arb_reg instance it connects to.
//   Signals:
//     in_valid  [NCH]        per-channel request
//     in_data   [NCH*WIDTH]  channel k at bits [k*WIDTH +: WIDTH]
//     in_ready  [NCH]        per-channel accept (one-hot or zero)
//     force_en, force_sel    static-select mode and forced channel
//     out_valid, out_data, out_sel   registered output word and its source
//     out_ready              consumer accepts out_data this cycle
//   Modports:
//     master  producers + consumer (drives requests, data, out_ready)
//     slave   the mux itself
interface mux_arb_reg_if #(
    parameter int WIDTH = 19,
    parameter int NCH   = 4
);
    localparam int unsigned SW = $clog2(NCH);

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 force_en;
    logic [SW-1:0]        force_sel;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SW-1:0]        out_sel;
    logic                 out_ready;

    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_arb_reg.sv
// mux_arb_reg
//   Registered NCH:1 multiplexer with valid/ready handshaking. Arbitrates
//   between requesting channels (round-robin or fixed lowest-index priority)
//   and holds the selected word in a single output register, so downstream
//   back-pressure never drops or duplicates data.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; clears the output register and ptr
//     bus    mux_arb_reg_if.slave: in_valid/in_data/in_ready, force_en/
//            force_sel, out_valid/out_data/out_sel/out_ready
//   Parameters:
//     WIDTH      data width per channel
//     NCH        number of channels (>=2, any value)
//     FIXED_PRI  0 = round-robin, 1 = fixed priority (lowest index wins)
module mux_arb_reg #(
    parameter int WIDTH     = 19,
    parameter int NCH       = 4,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          reset,
    mux_arb_reg_if.slave  bus
);
    localparam int unsigned SW = $clog2(NCH);

    logic [SW-1:0]    ptr;
    logic [NCH-1:0]   elig;
    logic             load;
    logic             any_e;
    logic             hi_found;
    logic             lo_found;
    logic [SW-1:0]    hi_g;
    logic [SW-1:0]    lo_g;
    logic [SW-1:0]    gnt;
    logic [WIDTH-1:0] gnt_data;
    logic [SW-1:0]    ptr_next;

    // Eligible set; a force_sel beyond the last channel matches nothing.
    always_comb begin
        load = !bus.out_valid || bus.out_ready;
        elig = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!bus.force_en || bus.force_sel == SW'(k))
                elig[k] = bus.in_valid[k];
        end
        any_e = |elig;
    end

    // Round-robin as two priority scans: the lowest eligible index at or
    // above ptr wins; if none, the lowest eligible index overall (wrap).
    // Fixed priority only ever uses the second scan.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_g     = '0;
        lo_g     = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (elig[k] && !lo_found) begin
                lo_found = 1'b1;
                lo_g     = SW'(k);
            end
            if (FIXED_PRI == 0 && elig[k] && !hi_found && SW'(k) >= ptr) begin
                hi_found = 1'b1;
                hi_g     = SW'(k);
            end
        end
        gnt = hi_found ? hi_g : lo_g;
    end

    always_comb begin
        bus.in_ready = '0;
        gnt_data     = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (gnt == SW'(k)) begin
                bus.in_ready[k] = !reset && load && any_e;
                gnt_data        = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
        ptr_next = (gnt == SW'(NCH - 1)) ? '0 : gnt + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else if (load) begin
            if (any_e) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= gnt_data;
                bus.out_sel   <= gnt;
                // Forced grants must not disturb the rotation order.
                if (FIXED_PRI == 0 && !bus.force_en)
                    ptr <= ptr_next;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg
//   Directed scenarios on three instances (NCH=4 round-robin, NCH=3 fixed
//   priority, NCH=3 round-robin) plus a randomized run of the NCH=4
//   instance against a cycle-level reference model.
module tb_mux_arb_reg;
    localparam int W  = 19;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    mux_arb_reg_if #(.WIDTH(W), .NCH(N))  bm ();
    mux_arb_reg_if #(.WIDTH(W), .NCH(N3)) bf ();
    mux_arb_reg_if #(.WIDTH(W), .NCH(N3)) br ();

    mux_arb_reg #(.WIDTH(W), .NCH(N), .FIXED_PRI(0)) u_main (
        .clk(clk), .reset(rst), .bus(bm)
    );
    mux_arb_reg #(.WIDTH(W), .NCH(N3), .FIXED_PRI(1)) u_fix3 (
        .clk(clk), .reset(rst), .bus(bf)
    );
    mux_arb_reg #(.WIDTH(W), .NCH(N3), .FIXED_PRI(0)) u_rr3 (
        .clk(clk), .reset(rst), .bus(br)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic set_main_data();
        for (int k = 0; k < N; k++) bm.in_data[k*W +: W] = W'(32'h100 + k);
    endtask

    // Reference grant: scan channels (p, p+1, ...) modulo n; -1 if none.
    function automatic int model_grant(input logic [N-1:0] v, input logic fen,
                                       input int fsel, input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (p + i) % n;
            if (((v >> k) & 1) != 0 && (!fen || fsel == k)) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bm.in_valid = '1;
        bm.out_ready = 1'b1;
        bm.force_en = 1'b0;
        set_main_data();
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            total++;
            if (bm.in_ready !== 4'b0000 || bm.out_valid !== 1'b0 ||
                bm.out_data !== 19'h0 || bm.out_sel !== 2'd0) begin
                $display("FAIL reset_state cyc=%0d got rdy=%b v=%b d=%h s=%0d exp rdy=0000 v=0 d=0 s=0",
                         i, bm.in_ready, bm.out_valid, bm.out_data, bm.out_sel);
            end else passed++;
        end
        rst = 1'b0;
        #1;
        total++;
        if (bm.in_ready !== 4'b0001) begin
            $display("FAIL reset_first_ready got=%b exp=0001", bm.in_ready);
        end else passed++;
        cyc();
        total++;
        if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd0 || bm.out_data !== 19'h100) begin
            $display("FAIL reset_first_grant got v=%b s=%0d d=%h exp v=1 s=0 d=100",
                     bm.out_valid, bm.out_sel, bm.out_data);
        end else passed++;
    endtask

    task automatic test_rotation();
        bm.in_valid = '1;
        bm.out_ready = 1'b1;
        set_main_data();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            total++;
            if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'(i % N) ||
                bm.out_data !== W'(32'h100 + (i % N))) begin
                $display("FAIL rotation step=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         i, bm.out_valid, bm.out_sel, bm.out_data, i % N, 32'h100 + (i % N));
            end else passed++;
        end
    endtask

    task automatic test_backpressure();
        bm.in_valid = '1;
        bm.out_ready = 1'b1;
        set_main_data();
        bm.in_data[0 +: W] = 19'h7FFFF;
        do_reset();
        cyc();
        bm.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bm.out_valid !== 1'b1 || bm.out_data !== 19'h7FFFF || bm.in_ready !== 4'b0000) begin
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b exp v=1 d=7ffff rdy=0000",
                         i, bm.out_valid, bm.out_data, bm.in_ready);
            end else passed++;
            cyc();
        end
        bm.out_ready = 1'b1;
        #1;
        total++;
        if (bm.in_ready !== 4'b0010 || bm.out_data !== 19'h7FFFF) begin
            $display("FAIL bp_release_ready got rdy=%b d=%h exp rdy=0010 d=7ffff",
                     bm.in_ready, bm.out_data);
        end else passed++;
        cyc();
        total++;
        if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd1 || bm.out_data !== 19'h101) begin
            $display("FAIL bp_no_bubble got v=%b s=%0d d=%h exp v=1 s=1 d=101",
                     bm.out_valid, bm.out_sel, bm.out_data);
        end else passed++;
        set_main_data();
    endtask

    task automatic test_sparse_wrap();
        logic [N-1:0] exp_r [3];
        logic [1:0]   exp_s [3];
        exp_r[0] = 4'b1000; exp_r[1] = 4'b0010; exp_r[2] = 4'b1000;
        exp_s[0] = 2'd3;    exp_s[1] = 2'd1;    exp_s[2] = 2'd3;
        bm.out_ready = 1'b1;
        set_main_data();
        bm.in_valid = 4'b0010;
        do_reset();
        cyc();                      // grant 1 moves ptr to 2
        bm.in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bm.in_ready !== exp_r[i]) begin
                $display("FAIL sparse_ready step=%0d got=%b exp=%b", i, bm.in_ready, exp_r[i]);
            end else passed++;
            cyc();
            total++;
            if (bm.out_sel !== exp_s[i] || bm.out_data !== W'(32'h100 + exp_s[i])) begin
                $display("FAIL sparse_grant step=%0d got s=%0d d=%h exp s=%0d d=%h",
                         i, bm.out_sel, bm.out_data, exp_s[i], 32'h100 + exp_s[i]);
            end else passed++;
        end
    endtask

    task automatic test_force();
        bm.in_valid = '1;
        bm.out_ready = 1'b1;
        bm.force_en = 1'b0;
        set_main_data();
        do_reset();
        cyc();                      // grant 0, ptr = 1
        bm.force_en = 1'b1;
        bm.force_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bm.in_ready !== 4'b0100) begin
                $display("FAIL force_ready cyc=%0d got=%b exp=0100", i, bm.in_ready);
            end else passed++;
            cyc();
            total++;
            if (bm.out_valid !== 1'b1 || bm.out_sel !== 2'd2) begin
                $display("FAIL force_grant cyc=%0d got v=%b s=%0d exp v=1 s=2",
                         i, bm.out_valid, bm.out_sel);
            end else passed++;
        end
        bm.force_en = 1'b0;
        #1;
        total++;
        if (bm.in_ready !== 4'b0010) begin
            $display("FAIL force_ptr_kept got=%b exp=0010", bm.in_ready);
        end else passed++;
        bm.force_en = 1'b1;
        bm.force_sel = 2'd3;
        bm.in_valid = 4'b0111;
        #1;
        total++;
        if (bm.in_ready !== 4'b0000) begin
            $display("FAIL force_invalid_ready got=%b exp=0000", bm.in_ready);
        end else passed++;
        cyc();
        total++;
        if (bm.out_valid !== 1'b0 || bm.out_sel !== 2'd2 || bm.out_data !== 19'h102) begin
            $display("FAIL force_drain got v=%b s=%0d d=%h exp v=0 s=2 d=102",
                     bm.out_valid, bm.out_sel, bm.out_data);
        end else passed++;
        bm.force_en = 1'b0;
        bm.in_valid = '0;
    endtask

    task automatic test_fixed_pri();
        for (int k = 0; k < N3; k++) bf.in_data[k*W +: W] = W'(32'h200 + k);
        bf.in_valid = 3'b110;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bf.in_ready !== 3'b010) begin
                $display("FAIL fixed_ready cyc=%0d got=%b exp=010", i, bf.in_ready);
            end else passed++;
            cyc();
            total++;
            if (bf.out_valid !== 1'b1 || bf.out_sel !== 2'd1 || bf.out_data !== 19'h201) begin
                $display("FAIL fixed_grant cyc=%0d got v=%b s=%0d d=%h exp v=1 s=1 d=201",
                         i, bf.out_valid, bf.out_sel, bf.out_data);
            end else passed++;
        end
        bf.in_valid = 3'b100;
        cyc();
        total++;
        if (bf.out_sel !== 2'd2 || bf.out_data !== 19'h202) begin
            $display("FAIL fixed_only2 got s=%0d d=%h exp s=2 d=202", bf.out_sel, bf.out_data);
        end else passed++;
        bf.in_valid = '0;
    endtask

    task automatic test_rr3_wrap();
        for (int k = 0; k < N3; k++) br.in_data[k*W +: W] = W'(32'h300 + k);
        br.in_valid = 3'b100;
        do_reset();
        cyc();                      // grant 2, ptr wraps to 0
        total++;
        if (br.out_sel !== 2'd2) begin
            $display("FAIL rr3_first got s=%0d exp s=2", br.out_sel);
        end else passed++;
        br.in_valid = 3'b111;
        #1;
        total++;
        if (br.in_ready !== 3'b001) begin
            $display("FAIL rr3_wrap_ready got=%b exp=001", br.in_ready);
        end else passed++;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (br.out_sel !== 2'(i % N3) || br.out_data !== W'(32'h300 + (i % N3))) begin
                $display("FAIL rr3_rotation step=%0d got s=%0d d=%h exp s=%0d d=%h",
                         i, br.out_sel, br.out_data, i % N3, 32'h300 + (i % N3));
            end else passed++;
        end
        br.force_en = 1'b1;
        br.force_sel = 2'd3;
        #1;
        total++;
        if (br.in_ready !== 3'b000) begin
            $display("FAIL rr3_force_oob got=%b exp=000", br.in_ready);
        end else passed++;
        cyc();
        total++;
        if (br.out_valid !== 1'b0) begin
            $display("FAIL rr3_force_oob_drain got v=%b exp v=0", br.out_valid);
        end else passed++;
        br.force_en = 1'b0;
        br.in_valid = '0;
    endtask

    task automatic test_random();
        logic         m_ov;
        logic [W-1:0] m_od;
        logic [1:0]   m_os;
        int           m_ptr;
        int           g;
        logic         ld;
        logic [N-1:0] exp_rdy;
        int unsigned  fails_before;
        bm.force_en = 1'b0;
        bm.in_valid = '0;
        bm.out_ready = 1'b1;
        do_reset();
        m_ov = 1'b0; m_od = '0; m_os = '0; m_ptr = 0;
        fails_before = total - passed;
        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(0, 49) == 0);
            bm.in_valid  = 4'($urandom());
            bm.in_data   = 76'({$urandom(), $urandom(), $urandom()});
            bm.out_ready = ($urandom_range(0, 9) < 7);
            bm.force_en  = ($urandom_range(0, 6) == 0);
            bm.force_sel = 2'($urandom());
            g  = model_grant(bm.in_valid, bm.force_en, int'(bm.force_sel), m_ptr, N);
            ld = !m_ov || bm.out_ready;
            exp_rdy = (!rst && ld && g >= 0) ? 4'(1 << g) : 4'b0000;
            @(negedge clk);
            total++;
            if (bm.in_ready !== exp_rdy) begin
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bm.in_ready, exp_rdy);
            end else passed++;
            total++;
            if (bm.out_valid !== m_ov || bm.out_data !== m_od || bm.out_sel !== m_os) begin
                $display("FAIL rnd_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                         c, bm.out_valid, bm.out_data, bm.out_sel, m_ov, m_od, m_os);
            end else passed++;
            @(posedge clk);
            if (rst) begin
                m_ov = 1'b0; m_od = '0; m_os = '0; m_ptr = 0;
            end else if (ld) begin
                if (g >= 0) begin
                    m_ov = 1'b1;
                    m_od = W'(bm.in_data >> (g * W));
                    m_os = 2'(g);
                    if (!bm.force_en) m_ptr = (g + 1) % N;
                end else begin
                    m_ov = 1'b0;
                end
            end
            #1;
            if (total - passed > fails_before + 20) break;
        end
        rst = 1'b0;
        bm.force_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bm.in_valid = '0; bm.in_data = '0; bm.force_en = 1'b0; bm.force_sel = '0; bm.out_ready = 1'b1;
        bf.in_valid = '0; bf.in_data = '0; bf.force_en = 1'b0; bf.force_sel = '0; bf.out_ready = 1'b1;
        br.in_valid = '0; br.in_data = '0; br.force_en = 1'b0; br.force_sel = '0; br.out_ready = 1'b1;
        test_reset();
        test_rotation();
        test_backpressure();
        test_sparse_wrap();
        test_force();
        test_fixed_pri();
        test_rr3_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
